// File: rtl/line_burst_adaptor_pkg.sv
// Shared types and sizing for the cache-line to memory-burst adaptor.
// Line/beat geometry lives here so the top and the line buffer agree on it.
package line_adaptor_types;

  localparam int S_OFFSET  = 5;
  localparam int S_LINE    = 256;
  localparam int S_BURST   = 64;
  localparam int NUM_BEATS = S_LINE / S_BURST;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } adaptor_state_t;

  // Clears the byte-within-line bits so every burst starts on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int offset_bits);
    logic [31:0] mask;
    mask = ~((32'd1 << offset_bits) - 32'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/line_burst_adaptor_buffer.sv
// Line-wide register split into beat-sized slices; a slice can be loaded on
// its own (read assembly) or all slices at once (write line capture).
module line_buffer #(
  parameter  int LINE_W = 256,
  parameter  int BEAT_W = 64,
  localparam int NBEATS = LINE_W / BEAT_W,
  localparam int IDX_W  = $clog2(NBEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slice_load_i,
  input  logic [IDX_W-1:0]  slice_idx_i,
  input  logic [BEAT_W-1:0] slice_data_i,
  input  logic              line_load_i,
  input  logic [LINE_W-1:0] line_data_i,
  output logic [LINE_W-1:0] line_o
);

  for (genvar gi = 0; gi < NBEATS; gi++) begin : g_slice
    logic [BEAT_W-1:0] slice_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        slice_q <= '0;
      end else if (line_load_i) begin
        slice_q <= line_data_i[gi*BEAT_W +: BEAT_W];
      end else if (slice_load_i && (slice_idx_i == IDX_W'(gi))) begin
        slice_q <= slice_data_i;
      end
    end

    assign line_o[gi*BEAT_W +: BEAT_W] = slice_q;
  end

endmodule

// File: rtl/line_burst_adaptor.sv
// Turns one cache line read/write into a num_beats-beat memory burst.
// Define LINE_ADAPTOR_EARLY_RESP_EN to answer reads in the last-beat cycle.
module line_burst_adaptor
  import line_adaptor_types::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_line   = S_LINE,
  parameter int s_burst  = S_BURST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pmem_address,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [s_line-1:0]  pmem_wdata,
  output logic [s_line-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic [31:0]        burst_address,
  output logic               burst_read,
  output logic               burst_write,
  output logic [s_burst-1:0] burst_wdata,
  input  logic [s_burst-1:0] burst_rdata,
  input  logic               burst_resp
);

  localparam int num_beats = s_line / s_burst;
  localparam int cnt_w     = $clog2(num_beats);
  localparam logic [cnt_w-1:0] LAST_BEAT = cnt_w'(num_beats - 1);

`ifdef LINE_ADAPTOR_EARLY_RESP_EN
  localparam adaptor_state_t RD_EXIT = IDLE;
`else
  localparam adaptor_state_t RD_EXIT = DONE;
`endif

  adaptor_state_t    state_q, state_d;
  logic [cnt_w-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;

  logic              rd_beat;
  logic              last_rd_beat;
  logic              wr_capture;
  logic [s_line-1:0] rd_line;
  logic [s_line-1:0] wr_line;

  assign rd_beat      = (state_q == RD) && burst_resp;
  assign last_rd_beat = rd_beat && (cnt_q == LAST_BEAT);
  assign wr_capture   = (state_q == IDLE) && pmem_write;

  // Read assembly: beat n lands in slice n.
  line_buffer #(
    .LINE_W (s_line),
    .BEAT_W (s_burst)
  ) u_rd_buf (
    .clk          (clk),
    .rst          (rst),
    .slice_load_i (rd_beat),
    .slice_idx_i  (cnt_q),
    .slice_data_i (burst_rdata),
    .line_load_i  (1'b0),
    .line_data_i  ('0),
    .line_o       (rd_line)
  );

  // Write line captured whole when the request is accepted; kept separate so
  // pmem_rdata is not disturbed by writebacks.
  line_buffer #(
    .LINE_W (s_line),
    .BEAT_W (s_burst)
  ) u_wr_buf (
    .clk          (clk),
    .rst          (rst),
    .slice_load_i (1'b0),
    .slice_idx_i  ('0),
    .slice_data_i ('0),
    .line_load_i  (wr_capture),
    .line_data_i  (pmem_wdata),
    .line_o       (wr_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Writeback goes first so a dirty victim leaves before its fill.
        if (pmem_write) begin
          addr_d  = line_align(pmem_address, s_offset);
          state_d = WR;
        end else if (pmem_read) begin
          addr_d  = line_align(pmem_address, s_offset);
          state_d = RD;
        end
      end
      RD: begin
        if (burst_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = RD_EXIT;
          end
        end
      end
      WR: begin
        if (burst_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign burst_address = addr_q;
  assign burst_read    = (state_q == RD);
  assign burst_write   = (state_q == WR);
  assign burst_wdata   = (state_q == WR) ? wr_line[cnt_q*s_burst +: s_burst] : '0;

`ifdef LINE_ADAPTOR_EARLY_RESP_EN
  assign pmem_resp  = (state_q == DONE) || last_rd_beat;
  assign pmem_rdata = last_rd_beat ? {burst_rdata, rd_line[s_line-s_burst-1:0]} : rd_line;
`else
  assign pmem_resp  = (state_q == DONE);
  assign pmem_rdata = rd_line;
`endif

endmodule

// File: doc/line_burst_adaptor.md
Name: line_burst_adaptor

Overview:
- Responder for the cache's physical-memory line interface: the `pmem_*` port set on the cache.
- Accepts one 256-bit line read or write per request.
- Converts it into a 4-beat, 64-bit burst on the memory bus.
- Read bursts are collected into a line buffer, then returned; write lines are serialized beat by beat.
- Sits between the instruction/data caches (or their arbiter) and physical memory.

Parameters:
- s_offset, 5, line offset bits; the line holds 2**s_offset bytes.
- s_line, 256, line width in bits (8*2**s_offset).
- s_burst, 64, memory beat width in bits.
- num_beats, 4, s_line/s_burst; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pmem_address  in  32  line request address from cache.
- pmem_read  in  1  line read request; held until pmem_resp.
- pmem_write  in  1  line write request; held until pmem_resp.
- pmem_wdata  in  s_line  write line data.
- pmem_rdata  out  s_line  assembled read line.
- pmem_resp  out  1  single-cycle request completion.
- burst_address  out  32  line-aligned memory address.
- burst_read  out  1  memory burst read.
- burst_write  out  1  memory burst write.
- burst_wdata  out  s_burst  current write beat.
- burst_rdata  in  s_burst  read beat.
- burst_resp  in  1  beat valid/accepted; high for num_beats consecutive-or-gapped cycles per burst.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values:
  - state=IDLE.
  - pmem_resp, burst_read, burst_write = 0.
  - beat counter = 0.
  - line buffer = 0, so pmem_rdata = 0.
  - burst_address = 0.
  - burst_wdata = 0.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - On pmem_write, latch address {pmem_address[31:s_offset], s_offset'b0} and pmem_wdata, then go to WR.
  - Else on pmem_read, latch the aligned address and go to RD.
  - If both are asserted, write wins (writeback precedes fill); the read is served as a separate later request.
- RD:
  - burst_read=1.
  - Each cycle with burst_resp=1: store burst_rdata into line buffer slice [64*cnt +: 64], cnt++.
  - Beat 0 lands in the low bits.
  - When beat num_beats-1 is captured, go to DONE.
- WR:
  - burst_write=1; burst_wdata = latched line slice [64*cnt +: 64].
  - Each burst_resp advances cnt; after the last beat, go to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle; pmem_rdata is stable from this cycle until the next read completes.
  - cnt is cleared, then go to IDLE.
- Handshake:
  - burst_read/burst_write stay high through the whole burst and drop in the cycle after the last burst_resp.
  - burst_resp in IDLE or DONE is ignored.
- Latency, gapless memory: request seen in cycle 0 → burst starts cycle 1 → last beat cycle 4 → pmem_resp cycle 5. Gaps in burst_resp stretch this one cycle each.
- The cache must not change request inputs before pmem_resp; the adaptor reads them only in IDLE.
- Counter width is clog2(num_beats) and wraps to 0 after the last beat.
- Reset mid-burst:
  - Returns to IDLE at that edge with all outputs cleared.
  - Remaining memory beats are ignored until a new request.

Optional Feature:
- Macro: LINE_ADAPTOR_EARLY_RESP_EN.
- Defined:
  - RD skips DONE. pmem_resp is asserted combinationally in the cycle the last burst_resp arrives.
  - pmem_rdata = buffer with its top slice replaced by burst_rdata in that cycle, registered afterwards.
  - Read latency is 4 cycles gapless. Writes are unchanged.
- Undefined: the behaviour above, with a DONE cycle on every request.

Decomposition:
- Add to a shared package `line_adaptor_types`:
  - enum adaptor_state_t {IDLE, RD, WR, DONE}.
  - Constants S_LINE=256, S_BURST=64, NUM_BEATS=4.
- One natural sub-module: line_buffer. It holds a 256-bit register with per-beat slice load (index, data, load) and whole-line load for writes.

Test Plan:
- Read, gapless: pmem_read, addr 0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → burst_address 0x0000_1220; pmem_rdata = {44..,33..,22..,11..}; pmem_resp one cycle, 5 cycles after request.
- Write: pmem_write, wdata {D,C,B,A}, one beat per cycle → burst_wdata A,B,C,D in order; burst_write high exactly 4 cycles; pmem_resp once.
- Gapped read: burst_resp pattern 1,0,1,0,0,1,1 → line assembled correctly; pmem_resp 8 cycles after request; burst_read high throughout.
- Simultaneous read+write: pmem_read=pmem_write=1 → write burst executes first; after pmem_resp with read still held → read burst follows.
- Reset after beat 2 of a read → next edge burst_read=0, pmem_resp=0, pmem_rdata=0. A new read after reset completes normally with fresh data.
- With LINE_ADAPTOR_EARLY_RESP_EN: gapless read → pmem_resp in the same cycle as the 4th burst_resp, 4 cycles after request; top 64 bits equal that beat.
